usb_cdc_input_reporter: RTL and testbench

- Parametrised successor to the fixed 8-bit `device_inputs` path that feeds the USB CDC device.
- Synchronises and debounces N_INPUTS pins and detects level changes per channel.
- Arbitrates change events into a byte FIFO, presented as a valid/ready stream to the CDC IN (device-to-host) data path.
- Drives an activity LED that is stretched after each byte is consumed.

---
 rtl/usb_cdc_input_reporter.sv | 140 ++++++++++++++
 tb/tb_usb_cdc_input_reporter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_cdc_input_reporter.sv
// usb_cdc_input_reporter: synchronises and debounces N_INPUTS pins, queues level-change
// events (lowest channel first) into a show-ahead byte FIFO and stretches an activity LED.
`default_nettype none

module usb_cdc_input_reporter #(
  parameter int N_INPUTS        = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int FIFO_DEPTH      = 4,
  parameter int LED_CYCLES      = 1200000
) (
  input  logic                             clk,
  input  logic                             rstn_i,
  input  logic [N_INPUTS-1:0]              inputs_i,
  input  logic                             snap_i,
  output logic [7:0]                       data_o,
  output logic                             valid_o,
  input  logic                             ready_i,
  output logic [N_INPUTS-1:0]              level_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  count_o,
  output logic                             led_o
);

  localparam int DBW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PTRW = $clog2(FIFO_DEPTH);
  localparam int CNTW = $clog2(FIFO_DEPTH + 1);
  localparam int LEDW = (LED_CYCLES > 1) ? $clog2(LED_CYCLES) : 1;

  localparam logic [DBW-1:0]  DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNTW-1:0] DEPTH    = CNTW'(FIFO_DEPTH);
  localparam logic [LEDW-1:0] LED_LOAD = LEDW'(LED_CYCLES - 1);

  logic [N_INPUTS-1:0] sync1, sync2, stable, pending;
  logic [N_INPUTS-1:0] db_set, clr_mask;
  logic [DBW-1:0]      db_cnt [N_INPUTS];

  logic                found, sel_level, pop, push;
  logic [6:0]          sel;
  logic [CNTW-1:0]     count_next;

  logic [7:0]          mem [FIFO_DEPTH];
  logic [PTRW-1:0]     wr_ptr, rd_ptr;
  logic [LEDW-1:0]     led_cnt;

  assign level_o = stable;
  assign data_o  = mem[rd_ptr];

  always_comb begin
    for (int i = 0; i < N_INPUTS; i++) begin
      db_set[i] = (sync2[i] != stable[i]) && (db_cnt[i] == DB_LAST);
    end
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      for (int i = 0; i < N_INPUTS; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= inputs_i;
      sync2 <= sync1;
      for (int i = 0; i < N_INPUTS; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_set[i]) begin
          stable[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DBW'(1);
        end
      end
    end
  end

  // Descending scan so the lowest-index pending channel is the one left selected.
  always_comb begin
    found     = 1'b0;
    sel       = '0;
    sel_level = 1'b0;
    for (int i = N_INPUTS - 1; i >= 0; i--) begin
      if (pending[i]) begin
        found     = 1'b1;
        sel       = 7'(i);
        sel_level = stable[i];
      end
    end
  end

  assign pop  = valid_o && ready_i;
  assign push = found && ((count_o != DEPTH) || pop);

  always_comb begin
    for (int i = 0; i < N_INPUTS; i++) begin
      clr_mask[i] = push && (sel == 7'(i));
    end
  end

  always_comb begin
    count_next = count_o;
    if (push && !pop)      count_next = count_o + CNTW'(1);
    else if (pop && !push) count_next = count_o - CNTW'(1);
  end

  // A push into a full FIFO only happens alongside a pop, so it reuses the slot being vacated.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      pending <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
      valid_o <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      pending <= (pending & ~clr_mask) | db_set | {N_INPUTS{snap_i}};
      if (push) begin
        mem[wr_ptr] <= {sel_level, sel};
        wr_ptr      <= wr_ptr + PTRW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTRW'(1);
      count_o <= count_next;
      valid_o <= (count_next != '0);
    end
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      led_cnt <= '0;
      led_o   <= 1'b0;
    end else if (pop) begin
      led_cnt <= LED_LOAD;
      led_o   <= 1'b1;
    end else if (led_o) begin
      if (led_cnt == '0) led_o <= 1'b0;
      else               led_cnt <= led_cnt - LEDW'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_usb_cdc_input_reporter.sv
// tb_usb_cdc_input_reporter: table-driven, directed and randomised checks of the input reporter
// against an event-list / pop-time reference model.
`default_nettype none
`timescale 1ns/1ps

module tb_usb_cdc_input_reporter;

  localparam int N  = 8;
  localparam int DB = 4;
  localparam int FD = 4;
  localparam int LC = 10;

  logic         clk = 1'b0;
  logic         rstn_i, snap_i, ready_i;
  logic [N-1:0] inputs_i;
  logic [7:0]   data_o;
  logic         valid_o, led_o;
  logic [N-1:0] level_o;
  logic [2:0]   count_o;

  always #5 clk = ~clk;

  usb_cdc_input_reporter #(
    .N_INPUTS(N), .DEBOUNCE_CYCLES(DB), .FIFO_DEPTH(FD), .LED_CYCLES(LC)
  ) dut (
    .clk(clk), .rstn_i(rstn_i), .inputs_i(inputs_i), .snap_i(snap_i),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .level_o(level_o), .count_o(count_o), .led_o(led_o)
  );

  typedef struct {
    logic [7:0] pins;
    logic [7:0] level;
    int         nev;
    logic [7:0] first;
    logic [7:0] last;
  } vec_t;

  int         n_cmp, n_fail;
  int         cyc, last_pop, max_cnt;
  logic [7:0] got[$];
  int         stamp[$];
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pre-edge: record a pop. Post-edge: LED is high iff a pop happened 1..LC cycles ago.
  task automatic step();
    if (rstn_i && valid_o && ready_i) begin
      got.push_back(data_o);
      stamp.push_back(cyc);
      last_pop = cyc;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (!rstn_i) begin
      last_pop = -1000;
    end else begin
      chk("led", led_o, 32'((cyc - last_pop >= 1) && (cyc - last_pop <= LC)));
      chk("valid_vs_count", valid_o, 32'(count_o != 0));
      if (32'(count_o) > 32'(max_cnt)) max_cnt = int'(count_o);
      if (count_o > 3'(FD)) chk("count_bound", count_o, FD);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) step();
  endtask

  task automatic drain(input string name, input int n, input int budget);
    int k = 0;
    while (got.size() < n && k < budget) begin
      step();
      k++;
    end
    if (got.size() < n) chk({name, "_timeout"}, got.size(), n);
  endtask

  task automatic check_bytes(input string name);
    chk({name, "_nbytes"}, got.size(), exp_q.size());
    foreach (exp_q[j]) begin
      if (j < got.size()) chk($sformatf("%s_byte%0d", name, j), got[j], exp_q[j]);
    end
    got.delete();
    stamp.delete();
  endtask

  vec_t       vt[4];
  int         n;
  logic [7:0] prev, newp;

  initial begin
    n_cmp = 0; n_fail = 0; cyc = 0; last_pop = -1000; max_cnt = 0;
    rstn_i = 1'b0; inputs_i = '0; snap_i = 1'b0; ready_i = 1'b0;

    vt[0] = '{8'h0F, 8'h0F, 2, 8'h81, 8'h83};
    vt[1] = '{8'hF0, 8'hF0, 8, 8'h00, 8'h87};
    vt[2] = '{8'hF1, 8'hF1, 1, 8'h80, 8'h80};
    vt[3] = '{8'h00, 8'h00, 5, 8'h00, 8'h07};

    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_level", level_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_count", count_o, 0);
    chk("rst_led", led_o, 0);
    rstn_i = 1'b1;

    // Latency: first valid observed after edge k+6 (7th step counting edge k as the first).
    ready_i = 1'b1;
    inputs_i = 8'h05;
    for (n = 1; n <= 20; n++) begin
      step();
      if (valid_o) break;
    end
    chk("lat_first_valid", n, 7);
    chk("lat_level", level_o, 8'h05);
    drain("lat", 2, 20);
    settle(DB + 6);
    exp_q = {8'h80, 8'h82};
    check_bytes("lat");

    for (int v = 0; v < 4; v++) begin
      inputs_i = vt[v].pins;
      drain($sformatf("vec%0d", v), vt[v].nev, 60);
      settle(DB + 6);
      chk($sformatf("vec%0d_level", v), level_o, vt[v].level);
      chk($sformatf("vec%0d_count", v), count_o, 0);
      chk($sformatf("vec%0d_nbytes", v), got.size(), vt[v].nev);
      if (got.size() > 0) begin
        chk($sformatf("vec%0d_first", v), got[0], vt[v].first);
        chk($sformatf("vec%0d_last", v), got[got.size()-1], vt[v].last);
      end
      got.delete();
      stamp.delete();
    end

    // Glitch of 3 clocks on channel 3 must be filtered.
    max_cnt = 0;
    inputs_i = 8'h08;
    settle(3);
    inputs_i = 8'h00;
    settle(15);
    chk("glitch_nbytes", got.size(), 0);
    chk("glitch_maxcnt", max_cnt, 0);
    chk("glitch_level", level_o, 8'h00);
    chk("glitch_count", count_o, 0);

    // Backpressure with a coalesced double toggle on channel 6 while pending.
    ready_i = 1'b0;
    inputs_i = 8'h3F;
    settle(20);
    chk("bp_count_full", count_o, 4);
    chk("bp_valid", valid_o, 1);
    chk("bp_head", data_o, 8'h80);
    inputs_i = 8'h7F;
    settle(10);
    chk("bp_level_up", level_o, 8'h7F);
    chk("bp_head_hold", data_o, 8'h80);
    inputs_i = 8'h3F;
    settle(10);
    chk("bp_level_down", level_o, 8'h3F);
    chk("bp_count_still_full", count_o, 4);
    ready_i = 1'b1;
    step();
    chk("bp_pushpop_full", count_o, 4);
    drain("bp", 7, 40);
    settle(DB + 6);
    exp_q = {8'h80, 8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h06};
    check_bytes("bp");

    inputs_i = 8'hA0;
    drain("toA0", 6, 40);
    settle(DB + 6);
    exp_q = {8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h87};
    check_bytes("toA0");

    // Snapshot: eight back-to-back reports with occupancy never above 1.
    max_cnt = 0;
    snap_i = 1'b1;
    step();
    snap_i = 1'b0;
    drain("snap", 8, 40);
    settle(4);
    chk("snap_maxcnt", max_cnt, 1);
    for (int j = 1; j < 8; j++) begin
      if (j < stamp.size()) chk($sformatf("snap_consec%0d", j), stamp[j] - stamp[0], j);
    end
    exp_q = {8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h85, 8'h06, 8'h87};
    check_bytes("snap");

    // LED stretch: pops at t and t+5; the per-step model checks led_o through t+16.
    settle(LC + 2);
    ready_i = 1'b0;
    inputs_i = 8'hA3;
    settle(10);
    chk("led_count2", count_o, 2);
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    settle(4);
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    settle(LC + 6);
    if (stamp.size() == 2) chk("led_pop_gap", stamp[1] - stamp[0], 5);
    exp_q = {8'h80, 8'h81};
    check_bytes("led");

    // Asynchronous reset mid-stream, then rediscovery of the held-high pins.
    inputs_i = 8'hAF;
    settle(10);
    chk("mid_count2", count_o, 2);
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    settle(2);
    chk("mid_led_on", led_o, 1);
    #2 rstn_i = 1'b0;
    #1;
    chk("arst_valid", valid_o, 0);
    chk("arst_led", led_o, 0);
    chk("arst_count", count_o, 0);
    chk("arst_level", level_o, 0);
    chk("arst_data", data_o, 0);
    @(negedge clk);
    got.delete();
    stamp.delete();
    last_pop = -1000;
    rstn_i = 1'b1;
    ready_i = 1'b1;
    drain("post_rst", 6, 40);
    settle(DB + 6);
    exp_q = {8'h80, 8'h81, 8'h82, 8'h83, 8'h85, 8'h87};
    check_bytes("post_rst");

    // Random pin patterns with random backpressure; model = changed bits in index order.
    prev = 8'hAF;
    for (int r = 0; r < 12; r++) begin
      int k;
      newp = 8'($urandom);
      exp_q.delete();
      for (int i = 0; i < N; i++) begin
        if (newp[i] != prev[i]) exp_q.push_back({newp[i], 7'(i)});
      end
      inputs_i = newp;
      k = 0;
      while (got.size() < exp_q.size() && k < 400) begin
        ready_i = 1'($urandom_range(0, 1));
        step();
        k++;
      end
      if (got.size() < exp_q.size()) chk($sformatf("rnd%0d_timeout", r), got.size(), exp_q.size());
      ready_i = 1'b1;
      settle(DB + 6);
      chk($sformatf("rnd%0d_level", r), level_o, newp);
      chk($sformatf("rnd%0d_count", r), count_o, 0);
      check_bytes($sformatf("rnd%0d", r));
      prev = newp;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
